// File: rtl/pipe_stage.sv
// Pipeline register with valid/ready handshake, optional 2-entry skid buffer and synchronous flush.
// Payload is opaque and passed bit-exact; data registers reset to RESET_VAL.
module pipe_stage #(
  parameter int unsigned      WIDTH          = 64,
  parameter bit               SKID           = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  if (SKID) begin : gen_skid
    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;

    // in_ready_q tracks (next state != FULL) so upstream never sees a combinational path.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q    <= StEmpty;
        main_q     <= RESET_VAL;
        skid_q     <= RESET_VAL;
        in_ready_q <= 1'b1;
      end else if (flush_i) begin
        state_q    <= StEmpty;
        in_ready_q <= 1'b1;
        if (CLEAR_ON_FLUSH) begin
          main_q <= RESET_VAL;
          skid_q <= RESET_VAL;
        end
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              main_q  <= in_data_i;
              state_q <= StBusy;
            end
            in_ready_q <= 1'b1;
          end
          StBusy: begin
            if (in_fire && out_fire) begin
              main_q     <= in_data_i;
              in_ready_q <= 1'b1;
            end else if (in_fire) begin
              skid_q     <= in_data_i;
              state_q    <= StFull;
              in_ready_q <= 1'b0;
            end else if (out_fire) begin
              state_q    <= StEmpty;
              in_ready_q <= 1'b1;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          StFull: begin
            if (out_fire) begin
              main_q     <= skid_q;
              state_q    <= StBusy;
              in_ready_q <= 1'b1;
            end else begin
              in_ready_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;

    always_comb begin
      count_o = 2'd0;
      unique case (state_q)
        StEmpty: count_o = 2'd0;
        StBusy:  count_o = 2'd1;
        StFull:  count_o = 2'd2;
        default: count_o = 2'd0;
      endcase
    end
  end else begin : gen_no_skid
    logic             valid_q;
    logic [WIDTH-1:0] main_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (flush_i) begin
        valid_q <= 1'b0;
        if (CLEAR_ON_FLUSH) begin
          main_q <= RESET_VAL;
        end
      end else if (in_fire) begin
        valid_q <= 1'b1;
        main_q  <= in_data_i;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign count_o     = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: one skid instance (RESET_VAL=0x13) and one single-entry instance.
module tb_pipe_stage;

  logic        clock;
  logic        reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int unsigned n_checks;
  int unsigned n_errors;

  pipe_stage #(
    .WIDTH         (64),
    .SKID          (1'b1),
    .RESET_VAL     (64'h13),
    .CLEAR_ON_FLUSH(1'b1)
  ) u_dut_skid (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (a_flush),
    .in_valid_i (a_in_valid),
    .in_ready_o (a_in_ready),
    .in_data_i  (a_in_data),
    .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready),
    .out_data_o (a_out_data),
    .count_o    (a_count)
  );

  pipe_stage #(
    .WIDTH         (64),
    .SKID          (1'b0),
    .RESET_VAL     (64'h0),
    .CLEAR_ON_FLUSH(1'b1)
  ) u_dut_noskid (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (b_flush),
    .in_valid_i (b_in_valid),
    .in_ready_o (b_in_ready),
    .in_data_i  (b_in_data),
    .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready),
    .out_data_o (b_out_data),
    .count_o    (b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b1;

    #12;
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_count", a_count, 2'd0);
    check("rst_ready", a_in_ready, 1'b1);
    check("rst_data", a_out_data, 64'h13);
    check("rst_b_valid", b_out_valid, 1'b0);
    reset = 1'b1;
    step();

    // Stream with downstream always ready.
    a_in_valid = 1'b1; a_in_data = 64'h10;
    step();
    check("s0_data", a_out_data, 64'h10);
    check("s0_valid", a_out_valid, 1'b1);
    check("s0_count", a_count, 2'd1);
    a_in_data = 64'h11;
    step();
    check("s1_data", a_out_data, 64'h11);
    check("s1_count", a_count, 2'd1);
    a_in_data = 64'h12;
    step();
    check("s2_data", a_out_data, 64'h12);
    check("s2_valid", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    step();
    check("s_drain_valid", a_out_valid, 1'b0);

    // Backpressure fills the skid entry.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hA0;
    step();
    check("bp0_count", a_count, 2'd1);
    check("bp0_ready", a_in_ready, 1'b1);
    a_in_data = 64'hA1;
    step();
    check("bp1_count", a_count, 2'd2);
    check("bp1_ready", a_in_ready, 1'b0);
    check("bp1_data", a_out_data, 64'hA0);
    a_in_data = 64'hA2;
    step();
    check("bp2_count", a_count, 2'd2);
    check("bp2_data", a_out_data, 64'hA0);
    a_out_ready = 1'b1;
    step();
    check("bp3_data", a_out_data, 64'hA1);
    check("bp3_count", a_count, 2'd1);
    check("bp3_ready", a_in_ready, 1'b1);
    step();
    check("bp4_data", a_out_data, 64'hA2);
    check("bp4_count", a_count, 2'd1);
    a_in_valid = 1'b0;
    step();
    check("bp5_valid", a_out_valid, 1'b0);

    // Simultaneous in/out while BUSY.
    a_in_valid = 1'b1; a_in_data = 64'h5;
    step();
    check("sim0_data", a_out_data, 64'h5);
    a_in_data = 64'h6;
    step();
    check("sim1_data", a_out_data, 64'h6);
    check("sim1_count", a_count, 2'd1);
    a_in_valid = 1'b0;
    step();

    // Flush while FULL drops the incoming beat too.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h21;
    step();
    a_in_data = 64'h22;
    step();
    check("fl_pre_count", a_count, 2'd2);
    a_in_data = 64'hBB; a_flush = 1'b1;
    step();
    check("fl_valid", a_out_valid, 1'b0);
    check("fl_count", a_count, 2'd0);
    check("fl_ready", a_in_ready, 1'b1);
    check("fl_data", a_out_data, 64'h13);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    check("fl_post_valid", a_out_valid, 1'b0);
    check("fl_post_data", a_out_data, 64'h13);

    // Asynchronous reset while stalled.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h31;
    step();
    a_in_data = 64'h32;
    step();
    check("ar_pre_count", a_count, 2'd2);
    a_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar_valid", a_out_valid, 1'b0);
    check("ar_count", a_count, 2'd0);
    check("ar_data", a_out_data, 64'h13);
    #2 reset = 1'b1;
    a_out_ready = 1'b1;
    step();

    // Single-entry mode: combinational ready.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 64'h1;
    #1;
    check("ns_empty_ready", b_in_ready, 1'b1);
    step();
    check("ns0_valid", b_out_valid, 1'b1);
    check("ns0_data", b_out_data, 64'h1);
    check("ns0_count", b_count, 2'd1);
    check("ns0_ready", b_in_ready, 1'b0);
    b_in_data = 64'h2;
    step();
    check("ns_hold_data", b_out_data, 64'h1);
    b_out_ready = 1'b1;
    #1;
    check("ns_comb_ready", b_in_ready, 1'b1);
    step();
    check("ns1_data", b_out_data, 64'h2);
    b_in_data = 64'h3;
    step();
    check("ns2_data", b_out_data, 64'h3);
    check("ns2_valid", b_out_valid, 1'b1);
    b_in_valid = 1'b0;
    step();
    check("ns3_valid", b_out_valid, 1'b0);
    check("ns3_count", b_count, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
